spi_adc7476: RTL and testbench

SPI_ADC7476 -- requirements
Module: spi_adc7476

---
 rtl/spi_adc7476.sv | 127 ++++++++++++
 tb/tb_spi_adc7476.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/spi_adc7476.sv
// SPI master for the AD7476: one 16-SCLK frame per start strobe, 12-bit sample out.
// Optional build macro SPI_ADC_ZCHK_EN: flag frames whose four leading bits are nonzero.
module spi_adc7476 #(
  parameter int CLK_DIV = 2,
  parameter int QUIET   = 4
) (
  input  logic        clk,
  input  logic        NRST,
  input  logic        st,
  input  logic        SDAT,
  output logic        NCS,
  output logic        SCLK,
  output logic [11:0] DO,
  output logic        ok,
  output logic        busy,
  output logic        err
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int QW = (QUIET > 1) ? $clog2(QUIET) : 1;
  localparam logic [HW-1:0] HMAX = HW'(CLK_DIV - 1);
  localparam logic [QW-1:0] QMAX = QW'(QUIET - 1);
`ifdef SPI_ADC_ZCHK_EN
  localparam int SW = 16;
`else
  // Without the check only the trailing 12 bits of the frame are ever observed.
  localparam int SW = 12;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_QUIET} state_t;

  state_t        state;
  logic [HW-1:0] hcnt;
  logic [QW-1:0] qcnt;
  logic [3:0]    bcnt;
  logic [SW-1:0] shift;
`ifdef SPI_ADC_ZCHK_EN
  logic          err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      state <= S_IDLE;
      hcnt  <= '0;
      qcnt  <= '0;
      bcnt  <= '0;
      shift <= '0;
      NCS   <= 1'b1;
      SCLK  <= 1'b1;
      DO    <= '0;
      ok    <= 1'b0;
      busy  <= 1'b0;
`ifdef SPI_ADC_ZCHK_EN
      err_q <= 1'b0;
`endif
    end else begin
      ok <= 1'b0;
`ifdef SPI_ADC_ZCHK_EN
      err_q <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (st) begin
            state <= S_SETUP;
            NCS   <= 1'b0;
            busy  <= 1'b1;
            hcnt  <= '0;
          end
        end
        S_SETUP: begin
          if (hcnt == HMAX) begin
            hcnt  <= '0;
            bcnt  <= '0;
            SCLK  <= 1'b0;
            state <= S_SHIFT;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (hcnt == HMAX) begin
            hcnt <= '0;
            if (!SCLK) begin
              // Sample on the same edge that raises SCLK.
              SCLK  <= 1'b1;
              shift <= {shift[SW-2:0], SDAT};
            end else if (bcnt == 4'd15) begin
              bcnt  <= '0;
              qcnt  <= '0;
              NCS   <= 1'b1;
              state <= S_QUIET;
`ifdef SPI_ADC_ZCHK_EN
              if (|shift[15:12]) begin
                err_q <= 1'b1;
              end else begin
                DO <= shift[11:0];
                ok <= 1'b1;
              end
`else
              DO <= shift;
              ok <= 1'b1;
`endif
            end else begin
              bcnt <= bcnt + 1'b1;
              SCLK <= 1'b0;
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        S_QUIET: begin
          if (qcnt == QMAX) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            qcnt <= qcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc7476.sv
// Directed bench for spi_adc7476: CLK_DIV=2 and CLK_DIV=1 instances, each driven by a small ADC model.
module tb_spi_adc7476;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st0, sdat0, ncs0, sclk0, ok0, busy0, err0;
  logic        st1, sdat1, ncs1, sclk1, ok1, busy1, err1;
  logic [11:0] do0, do1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_adc7476 #(.CLK_DIV(2), .QUIET(4)) u0 (
    .clk(clk), .NRST(rst_n), .st(st0), .SDAT(sdat0), .NCS(ncs0), .SCLK(sclk0),
    .DO(do0), .ok(ok0), .busy(busy0), .err(err0)
  );

  spi_adc7476 #(.CLK_DIV(1), .QUIET(4)) u1 (
    .clk(clk), .NRST(rst_n), .st(st1), .SDAT(sdat1), .NCS(ncs1), .SCLK(sclk1),
    .DO(do1), .ok(ok1), .busy(busy1), .err(err1)
  );

  // ADC models: latch the next word on NCS fall, present MSB, advance after each SCLK rise.
  logic [15:0] next0 = '0, word0 = '0, next1 = '0, word1 = '0;
  int rises0 = 0, rises1 = 0;

  always @(negedge ncs0) begin
    word0 = next0; rises0 = 0; sdat0 = next0[15];
  end
  always @(posedge sclk0) if (!ncs0) begin
    rises0++;
    if (rises0 < 16) sdat0 = word0[4'(15 - rises0)];
  end
  always @(negedge ncs1) begin
    word1 = next1; rises1 = 0; sdat1 = next1[15];
  end
  always @(posedge sclk1) if (!ncs1) begin
    rises1++;
    if (rises1 < 16) sdat1 = word1[4'(15 - rises1)];
  end

  logic sel = 1'b0;
  logic c_ncs, c_sclk, c_ok, c_err, c_busy;
  always_comb begin
    c_ncs  = sel ? ncs1  : ncs0;
    c_sclk = sel ? sclk1 : sclk0;
    c_ok   = sel ? ok1   : ok0;
    c_err  = sel ? err1  : err0;
    c_busy = sel ? busy1 : busy0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame observations, cycle 0 = the cycle where st is high.
  int r_ok, r_err, r_lo, r_fr, r_lr, r_done;

  task automatic run_frame(input logic s, input logic [15:0] w);
    logic prev_sclk;
    int cyc;
    sel = s;
    if (s) begin next1 = w; st1 = 1'b1; end
    else   begin next0 = w; st0 = 1'b1; end
    r_ok = -1; r_err = -1; r_lo = 0; r_fr = -1; r_lr = -1; r_done = -1;
    @(negedge clk);
    st0 = 1'b0; st1 = 1'b0;
    prev_sclk = 1'b1;
    cyc = 1;
    while (cyc < 400 && r_done < 0) begin
      if (!c_ncs) r_lo++;
      if (c_sclk && !prev_sclk) begin
        if (r_fr < 0) r_fr = cyc;
        r_lr = cyc;
      end
      prev_sclk = c_sclk;
      if (c_ok && r_ok < 0) r_ok = cyc;
      if (c_err && r_err < 0) r_err = cyc;
      if (!c_busy) r_done = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  logic [15:0] b2b_words [3];
  logic [11:0] got [3];
  int got_cyc [3];
  int n, cyc, hi_run, min_gap, okcnt;
  logic seen_low;

  initial begin
    rst_n = 1'b0; st0 = 1'b0; st1 = 1'b0; sdat0 = 1'b0; sdat1 = 1'b0;
    b2b_words[0] = 16'h0111; b2b_words[1] = 16'h0222; b2b_words[2] = 16'h0333;
    repeat (3) @(negedge clk);
    check("rst_ncs", ncs0, 1); check("rst_sclk", sclk0, 1); check("rst_do", do0, 0);
    check("rst_ok", ok0, 0); check("rst_busy", busy0, 0); check("rst_err", err0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(0, 16'h0ABC);
    check("f1_ok_cyc", r_ok, 67); check("f1_ncs_low", r_lo, 66);
    check("f1_first_rise", r_fr, 5); check("f1_last_rise", r_lr, 65);
    check("f1_rises", rises0, 16); check("f1_do", do0, 12'hABC);
    check("f1_err", r_err, -1); check("f1_done", r_done, 71);

    run_frame(0, 16'h0FFF);
    check("fff_do", do0, 12'hFFF); check("fff_ok", r_ok, 67); check("fff_err", r_err, -1);
    run_frame(0, 16'h0000);
    check("zero_do", do0, 12'h000); check("zero_ok", r_ok, 67); check("zero_err", r_err, -1);

    run_frame(0, 16'h0456);
    check("pre_do", do0, 12'h456);
    run_frame(0, 16'h8123);
`ifdef SPI_ADC_ZCHK_EN
    check("zchk_err", r_err, 67); check("zchk_ok", r_ok, -1); check("zchk_do", do0, 12'h456);
`else
    check("nozchk_ok", r_ok, 67); check("nozchk_err", r_err, -1); check("nozchk_do", do0, 12'h123);
`endif
    check("zchk_done", r_done, 71);

    // st held high: frames may only start from IDLE.
    sel = 1'b0; next0 = b2b_words[0]; n = 0; hi_run = 0; min_gap = 999; seen_low = 1'b0;
    st0 = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (cyc < 400 && n < 3) begin
      if (!ncs0) begin
        if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
        seen_low = 1'b1; hi_run = 0;
      end else hi_run++;
      if (ok0) begin
        got[n] = do0; got_cyc[n] = cyc; n++;
        if (n < 3) next0 = b2b_words[n];
      end
      if (n < 3) begin @(negedge clk); cyc++; end
    end
    st0 = 1'b0;
    check("b2b_frames", n, 3);
    for (int i = 0; i < 3; i++) begin
      check("b2b_do", got[i], b2b_words[i][11:0]);
      check("b2b_ok_cyc", got_cyc[i], 67 + 71 * i);
    end
    check("b2b_min_gap", min_gap, 5);
    while (cyc < 500 && busy0) begin @(negedge clk); cyc++; end
    check("b2b_done", cyc, 213);

    // Reset in the middle of a frame.
    next0 = 16'h0777; st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ncs", ncs0, 1); check("mid_rst_sclk", sclk0, 1);
    check("mid_rst_do", do0, 0); check("mid_rst_busy", busy0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    okcnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (ok0 || err0) okcnt++;
    end
    check("mid_rst_no_ok", okcnt, 0);
    run_frame(0, 16'h0ABC);
    check("post_rst_ok", r_ok, 67); check("post_rst_do", do0, 12'hABC);

    run_frame(1, 16'h0555);
    check("div1_ok_cyc", r_ok, 34); check("div1_first_rise", r_fr, 3);
    check("div1_last_rise", r_lr, 33); check("div1_rises", rises1, 16);
    check("div1_do", do1, 12'h555); check("div1_ncs_low", r_lo, 33);
    check("div1_done", r_done, 38);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
